// File: rtl/rst_seq_arty7.sv
// Reset sequencer for the 25 MHz MMCM domain: waits for a stable lock, then releases peripheral and core resets in order.
// Latency: periphRstn_o rises LOCK_STABLE_CYCLES clocks after the first synchronised lock cycle; coreRstn_o follows STAGE_GAP_CYCLES later.
// Backpressure: none; softRstReq_i is a one-cycle request, honoured only in RUN. Optional cause register: define RST_SEQ_CAUSE_EN.
module rst_seq_arty7 #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int SOFT_RST_CYCLES    = 32
) (
  input  logic       clk25Mhz_i,
  input  logic       RESETn_i,
  input  logic       mmcmLocked_i,
  input  logic       softRstReq_i,
`ifdef RST_SEQ_CAUSE_EN
  input  logic       rstCauseClr_i,
  output logic [2:0] rstCause_o,
`endif
  output logic       periphRstn_o,
  output logic       coreRstn_o,
  output logic       seqDone_o
);

  localparam int CNT_MAX_AB = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AB > SOFT_RST_CYCLES) ? CNT_MAX_AB : SOFT_RST_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    LOCK_STABLE,
    PERIPH_UP,
    RUN,
    SOFT_RST
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_pipe;
  logic                   rst_n;
  logic                   lock_sync;
  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   periph_nxt;
  logic                   core_nxt;

  // Board reset: assert asynchronously, release after SYNC_STAGES clean edges.
  always_ff @(posedge clk25Mhz_i or negedge RESETn_i) begin
    if (!RESETn_i) rst_sync <= '0;
    else           rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_n = rst_sync[SYNC_STAGES-1];

  // MMCM lock crosses into the clock domain; it only starts sampling once internal reset is released.
  always_ff @(posedge clk25Mhz_i or negedge rst_n) begin
    if (!rst_n) lock_pipe <= '0;
    else        lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], mmcmLocked_i};
  end

  assign lock_sync = lock_pipe[SYNC_STAGES-1];

  // Next-state and counter; lock loss overrides every other event. The edge that first sees
  // lock counts as the first stable cycle, so LOCK_STABLE is entered with the count at one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (state != WAIT_LOCK && !lock_sync) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_sync) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              state_nxt = PERIPH_UP;
            end else begin
              state_nxt = LOCK_STABLE;
              cnt_nxt   = CW'(1);
            end
          end
        end
        LOCK_STABLE: begin
          if (cnt == LOCK_LAST) state_nxt = PERIPH_UP;
          else                  cnt_nxt   = cnt + CW'(1);
        end
        PERIPH_UP: begin
          if (cnt == GAP_LAST) state_nxt = RUN;
          else                 cnt_nxt   = cnt + CW'(1);
        end
        RUN: begin
          if (softRstReq_i) state_nxt = SOFT_RST;
        end
        SOFT_RST: begin
          if (cnt == SOFT_LAST) state_nxt = RUN;
          else                  cnt_nxt   = cnt + CW'(1);
        end
        default: state_nxt = WAIT_LOCK;
      endcase
    end
    periph_nxt = (state_nxt == PERIPH_UP) || (state_nxt == RUN) || (state_nxt == SOFT_RST);
    core_nxt   = (state_nxt == RUN);
  end

  // State, counter and registered reset outputs; core release always implies peripheral release.
  always_ff @(posedge clk25Mhz_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      periphRstn_o <= 1'b0;
      coreRstn_o   <= 1'b0;
      seqDone_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      periphRstn_o <= periph_nxt;
      coreRstn_o   <= core_nxt;
      seqDone_o    <= core_nxt;
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic loss_evt;
  logic soft_evt;

  assign loss_evt = (state != WAIT_LOCK) && !lock_sync;
  assign soft_evt = (state == RUN) && lock_sync && softRstReq_i;

  // Sticky cause flags: board reset is implied by the reset value; a same-cycle set beats a clear.
  always_ff @(posedge clk25Mhz_i or negedge rst_n) begin
    if (!rst_n) rstCause_o <= 3'b001;
    else        rstCause_o <= (rstCauseClr_i ? 3'b000 : rstCause_o) | {soft_evt, loss_evt, 1'b0};
  end
`endif

endmodule

// File: tb/tb_rst_seq_arty7.sv
// Bench for rst_seq_arty7: directed scenarios plus randomized lock/reset/soft-request traffic.
// Reference model tracks run-length of synchronised lock and remaining soft-reset cycles.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rst_seq_arty7;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lock;
  logic       soft_req;
  logic       clr;
  logic       periph;
  logic       core;
  logic       done;
  logic [2:0] cause;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk = ~clk;

  rst_seq_arty7 #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .SOFT_RST_CYCLES   (5)
  ) dut (
    .clk25Mhz_i   (clk),
    .RESETn_i     (resetn),
    .mmcmLocked_i (lock),
    .softRstReq_i (soft_req),
`ifdef RST_SEQ_CAUSE_EN
    .rstCauseClr_i(clr),
    .rstCause_o   (cause),
`endif
    .periphRstn_o (periph),
    .coreRstn_o   (core),
    .seqDone_o    (done)
  );

`ifndef RST_SEQ_CAUSE_EN
  assign cause = 3'b001;
`endif

  // Reference model state
  int       rcount;     // edges seen with board reset released
  bit       lq[$];      // raw lock samples taken once internal reset is out
  int       run_len;    // consecutive edges that observed synchronised lock
  int       soft_left;  // remaining edges of an active soft reset
  bit       e_periph, e_core, e_done;
  bit [2:0] e_cause;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rcount    = 0;
    lq.delete();
    run_len   = 0;
    soft_left = 0;
    e_periph  = 0;
    e_core    = 0;
    e_done    = 0;
    e_cause   = 3'b001;
  endtask

  // One rising edge of the specification's behaviour.
  task automatic model_step();
    bit l_seen, in_run, loss, soft_set;
    if (!resetn) return;
    if (rcount < 2) begin
      rcount++;
      return;
    end
    // two synchroniser flops: the edge sees the lock sampled two edges earlier
    l_seen = (lq.size() >= 2) ? lq[lq.size()-2] : 1'b0;
    lq.push_back(lock);
    if (lq.size() > 4) void'(lq.pop_front());
    in_run   = e_core;
    loss     = 0;
    soft_set = 0;
    if (!l_seen) begin
      loss      = (run_len > 0);
      run_len   = 0;
      soft_left = 0;
    end else begin
      if (run_len < 1000) run_len++;
      if (soft_left > 0) soft_left--;
      else if (in_run && soft_req) begin
        soft_left = 5;
        soft_set  = 1;
      end
    end
    e_periph = (run_len >= 8);
    e_core   = (run_len >= 8 + 4) && (soft_left == 0);
    e_done   = e_core;
    e_cause  = (clr ? 3'b000 : e_cause) | {soft_set, loss, 1'b0};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("periph", {31'b0, periph}, {31'b0, e_periph});
    chk("core", {31'b0, core}, {31'b0, e_core});
    chk("done", {31'b0, done}, {31'b0, e_done});
    chk("core_implies_periph", {31'b0, core & ~periph}, 32'd0);
`ifdef RST_SEQ_CAUSE_EN
    chk("cause", {29'b0, cause}, {29'b0, e_cause});
`endif
  endtask

  // Drive board reset away from the clock edge; assertion must clear outputs with no edge.
  task automatic set_rst(input logic v);
    resetn = v;
    if (!v) begin
      model_reset();
      #1;
      chk("async_periph", {31'b0, periph}, 32'd0);
      chk("async_core", {31'b0, core}, 32'd0);
      chk("async_done", {31'b0, done}, 32'd0);
    end
  endtask

  // Count edges until the chosen output (0 = periph, 1 = core) is high; -1 if it never rises.
  task automatic wait_rise(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (((which == 0) ? periph : core) == 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int lowcnt;
    resetn   = 1'b0;
    lock     = 1'b0;
    soft_req = 1'b0;
    clr      = 1'b0;
    model_reset();
    #5;
    chk("reset_periph", {31'b0, periph}, 32'd0);
    chk("reset_core", {31'b0, core}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
`ifdef RST_SEQ_CAUSE_EN
    chk("reset_cause", {29'b0, cause}, 32'd1);
`endif

    // Power-up: 2 reset sync + 2 lock sync + 8 stable
    lock = 1'b1;
    repeat (5) cycle();
    set_rst(1'b1);
    wait_rise(0, n);
    chk("pwr_periph_latency", n, 12);
    wait_rise(1, n);
    chk("pwr_core_gap", n, 4);
    chk("pwr_done_with_core", {31'b0, done}, 32'd1);

    // Soft reset, with a second request inside the pulse
    soft_req = 1'b1;
    cycle();
    soft_req = 1'b0;
    lowcnt = core ? 0 : 1;
    for (int i = 0; i < 20 && !core; i++) begin
      soft_req = (i == 2);
      cycle();
      if (!core) lowcnt++;
      chk("soft_periph_held", {31'b0, periph}, 32'd1);
    end
    soft_req = 1'b0;
    chk("soft_low_len", lowcnt, 5);

    // Lock loss in RUN: outputs drop on the third edge
    lock = 1'b0;
    cycle();
    chk("loss_edge1_core", {31'b0, core}, 32'd1);
    cycle();
    chk("loss_edge2_core", {31'b0, core}, 32'd1);
    cycle();
    chk("loss_edge3_core", {31'b0, core}, 32'd0);
    chk("loss_edge3_periph", {31'b0, periph}, 32'd0);
    chk("loss_edge3_done", {31'b0, done}, 32'd0);

    // Re-lock repeats the sequence: 2 sync + 8 stable, then gap 4
    lock = 1'b1;
    wait_rise(0, n);
    chk("relock_periph_latency", n, 10);
    wait_rise(1, n);
    chk("relock_core_gap", n, 4);

    // Lock glitch at stable count 5 restarts the full count
    set_rst(1'b0);
    repeat (2) cycle();
    set_rst(1'b1);
    repeat (9) cycle();
    lock = 1'b0;
    cycle();
    lock = 1'b1;
    cycle();
    cycle();
    chk("glitch_periph_held_low", {31'b0, periph}, 32'd0);
    wait_rise(0, n);
    chk("glitch_restart_latency", n, 8);

    // Async reset in PERIPH_UP, then a full restart from WAIT_LOCK
    cycle();
    chk("mid_periph_up_core", {31'b0, core}, 32'd0);
    set_rst(1'b0);
    #5;
    chk("mid_async_periph_still0", {31'b0, periph}, 32'd0);
    cycle();
    set_rst(1'b1);
    wait_rise(0, n);
    chk("mid_restart_latency", n, 12);
    wait_rise(1, n);
    chk("mid_restart_core_gap", n, 4);

    // Cause flags: lock loss then soft -> 111, clear -> 000, clear with soft -> 100
    lock = 1'b0;
    repeat (3) cycle();
    lock = 1'b1;
    wait_rise(1, n);
    soft_req = 1'b1;
    cycle();
    soft_req = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause_loss_soft", {29'b0, cause}, 32'd7);
`endif
    clr = 1'b1;
    cycle();
    clr = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause_cleared", {29'b0, cause}, 32'd0);
`endif
    repeat (6) cycle();
    clr      = 1'b1;
    soft_req = 1'b1;
    cycle();
    clr      = 1'b0;
    soft_req = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause_set_beats_clear", {29'b0, cause}, 32'd4);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!resetn) begin
        if ($urandom_range(0, 1) == 1) set_rst(1'b1);
      end else if ($urandom_range(0, 999) < 3) begin
        set_rst(1'b0);
      end
      if (lock) lock = ($urandom_range(0, 99) >= 2);
      else      lock = ($urandom_range(0, 99) < 20);
      soft_req = ($urandom_range(0, 99) < 8);
      clr      = ($urandom_range(0, 99) < 4);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
